if_stage: RTL and testbench

- Instruction-fetch front end: owns the fetch PC, issues in-order requests to instruction memory, buffers responses and hands {pc, instr} to ID over valid/ready.
- Sits directly upstream of ID and consumes the pipeline controller's IF flush plus the redirect target from branch resolution.
- Responses already in flight when a flush occurs are discarded so that only post-redirect instructions reach ID.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/fetch_queue.sv | 78 +++++++
 rtl/if_stage.sv | 105 ++++++++++
 tb/tb_if_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction-fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int unsigned PC_STEP = 4;

  // One fetch-queue slot: address issued, returned word, and whether the word has arrived.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time, filled oldest-first as
// responses return, and popped from the head once filled.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                alloc_i,
  input  logic [XLEN_DEF-1:0] alloc_pc_i,
  input  logic                fill_i,
  input  logic [31:0]         fill_data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                has_unfilled_o,
  output fetch_entry_t        head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q, nfilled_q;
  logic [PtrW-1:0] fill_ptr;

  // Filled entries are always a contiguous run starting at the head, so the oldest
  // unfilled slot sits nfilled places past the read pointer.
  always_comb begin
    fill_ptr       = rd_ptr_q + PtrW'(nfilled_q);
    full_o         = (cnt_q == CntW'(DEPTH));
    empty_o        = (cnt_q == '0);
    has_unfilled_o = (cnt_q != nfilled_q);
    head_o         = mem_q[rd_ptr_q];
  end

  // Queue storage and pointers; clear discards every entry in one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      nfilled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      nfilled_q <= '0;
    end else begin
      if (alloc_i) begin
        mem_q[wr_ptr_q] <= '{pc: alloc_pc_i, instr: 32'h0, filled: 1'b0};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (fill_i) begin
        mem_q[fill_ptr].instr  <= fill_data_i;
        mem_q[fill_ptr].filled <= 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q     <= cnt_q + CntW'(alloc_i) - CntW'(pop_i);
      nfilled_q <= nfilled_q + CntW'(fill_i) - CntW'(pop_i);
    end
  end

  // Only filled heads may leave, and fills need a waiting slot.
  a_pop_filled : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop_i && !clear_i) |-> (!empty_o && head_o.filled));
  a_fill_slot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fill_i && !clear_i) |-> has_unfilled_o);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests, tracks
// in-flight and to-be-dropped responses, and presents buffered {pc, instr} to ID.
// The queue entry type is sized by ifu_pkg::XLEN_DEF, so XLEN must match it.
module if_stage
  import ifu_pkg::*;
#(
  parameter int unsigned          XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]      RESET_PC = RESET_PC_DEF,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_if_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  logic         req_fire, rsp_drop, rsp_fill, id_fire;
  logic         q_full, q_empty, q_has_unfilled;
  fetch_entry_t q_head;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (flush_if_i),
    .alloc_i        (req_fire),
    .alloc_pc_i     (pc_q),
    .fill_i         (rsp_fill),
    .fill_data_i    (imem_rsp_data_i),
    .pop_i          (id_fire),
    .full_o         (q_full),
    .empty_o        (q_empty),
    .has_unfilled_o (q_has_unfilled),
    .head_o         (q_head)
  );

  // Handshake glue; nothing is offered to memory or ID while flushing or held in reset.
  always_comb begin
    imem_req_addr_o  = pc_q;
    imem_req_valid_o = rst_ni && !flush_if_i && !q_full && (outstanding_q < CntW'(DEPTH));
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    rsp_drop         = imem_rsp_valid_i && (drop_cnt_q != '0);
    rsp_fill         = imem_rsp_valid_i && (drop_cnt_q == '0) && !flush_if_i;
    id_valid_o       = rst_ni && !q_empty && q_head.filled && !flush_if_i;
    id_fire          = id_valid_o && id_ready_i;
    id_pc_o          = q_head.pc;
    id_instr_o       = q_head.instr;
  end

  // Next PC and counters.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid_i);
    drop_cnt_d    = drop_cnt_q;
    if (flush_if_i) begin
      // Redirect target is forced word-aligned.
      pc_d       = redirect_pc_i & ~XLEN'(3);
      // Every response still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding_q - CntW'(imem_rsp_valid_i);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(PC_STEP);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // A response must either be dropped or land in a waiting slot.
  a_rsp_has_home : assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> ((drop_cnt_q != '0) || q_has_unfilled));
  a_outstanding_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_q <= CntW'(DEPTH));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a simple in-order memory model and scoreboards for
// both the request stream and the ID stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_if_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;

  if_stage #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000),
    .DEPTH    (2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_if_i       (flush_if_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Values applied at the next cycle boundary.
  logic        n_rst = 1'b0;
  logic        n_flush = 1'b0;
  logic [31:0] n_redir = '0;
  logic        n_idr = 1'b0;
  logic        hold = 1'b0;
  int          budget = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, then log the request taken at the next rise.
  // Memory returns ~addr one cycle after the request unless held.
  task automatic cycle();
    logic [31:0] a;
    @(negedge clk);
    cyc++;
    rst_ni           = n_rst;
    flush_if_i       = n_flush;
    redirect_pc_i    = n_redir;
    id_ready_i       = n_idr;
    imem_req_ready_i = (budget > 0);
    if (!hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = ~a;
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    if (imem_req_valid_o && imem_req_ready_i) begin
      budget--;
      if (exp_req.size() == 0) begin
        chk("req_unexpected", imem_req_addr_o, 32'hxxxx_xxxx);
      end else begin
        chk("req_addr", imem_req_addr_o, exp_req.pop_front());
      end
      pend_addr.push_back(imem_req_addr_o);
      pend_due.push_back(cyc + 1);
    end
  endtask

  task automatic push_id(input logic [31:0] pc, input logic [31:0] ins);
    exp_pc.push_back(pc);
    exp_ins.push_back(ins);
  endtask

  // ID-side monitor: every accepted instruction must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_ni && id_valid_o && id_ready_i) begin
        if (exp_pc.size() == 0) begin
          chk("id_unexpected_pc", id_pc_o, 32'hxxxx_xxxx);
        end else begin
          chk("id_pc", id_pc_o, exp_pc.pop_front());
          chk("id_instr", id_instr_o, exp_ins.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    n_rst = 1'b0;
    repeat (2) cycle();
    chk("rst_id_valid", 32'(id_valid_o), 0);
    chk("rst_req_valid", 32'(imem_req_valid_o), 0);
    chk("rst_req_addr", imem_req_addr_o, 32'h8000_0000);
    chk("rst_id_pc", id_pc_o, 0);
    chk("rst_id_instr", id_instr_o, 0);
    chk("rst_outstanding", 32'(dut.outstanding_q), 0);

    // Streaming fetch with ID always ready.
    n_rst = 1'b1;
    n_idr = 1'b1;
    budget = 3;
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    exp_req.push_back(32'h8000_0008);
    push_id(32'h8000_0000, 32'h7FFF_FFFF);
    push_id(32'h8000_0004, 32'h7FFF_FFFB);
    push_id(32'h8000_0008, 32'h7FFF_FFF7);
    repeat (8) cycle();

    // ID stall: only DEPTH requests may issue and the head holds still.
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    n_idr = 1'b0;
    budget = 100;
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i >= 3) chk("stall_req_valid", 32'(imem_req_valid_o), 0);
    end
    chk("stall_id_valid", 32'(id_valid_o), 1);
    chk("stall_id_pc", id_pc_o, 32'h8000_0000);
    budget = 0;
    n_idr = 1'b1;
    push_id(32'h8000_0000, 32'h7FFF_FFFF);
    push_id(32'h8000_0004, 32'h7FFF_FFFB);
    repeat (4) cycle();

    // Flush with two requests in flight.
    hold = 1'b1;
    budget = 2;
    exp_req.push_back(32'h8000_0008);
    exp_req.push_back(32'h8000_000C);
    repeat (3) cycle();
    n_flush = 1'b1;
    n_redir = 32'h0000_1003;
    cycle();
    chk("flush_req_gate", 32'(imem_req_valid_o), 0);
    n_flush = 1'b0;
    hold = 1'b0;
    cycle();
    chk("flush2_drop_cnt", 32'(dut.drop_cnt_q), 2);
    chk("flush2_addr", imem_req_addr_o, 32'h0000_1000);
    budget = 1;
    exp_req.push_back(32'h0000_1000);
    push_id(32'h0000_1000, 32'hFFFF_EFFF);
    repeat (6) cycle();

    // Flush coinciding with a response, one more still outstanding.
    hold = 1'b1;
    budget = 2;
    exp_req.push_back(32'h0000_1004);
    exp_req.push_back(32'h0000_1008);
    repeat (3) cycle();
    n_flush = 1'b1;
    n_redir = 32'h0000_4000;
    hold = 1'b0;
    cycle();
    chk("flushrsp_id_valid", 32'(id_valid_o), 0);
    chk("flushrsp_req_valid", 32'(imem_req_valid_o), 0);
    n_flush = 1'b0;
    cycle();
    chk("flushrsp_drop_cnt", 32'(dut.drop_cnt_q), 1);
    chk("flushrsp_outstanding", 32'(dut.outstanding_q), 1);
    budget = 1;
    exp_req.push_back(32'h0000_4000);
    push_id(32'h0000_4000, 32'hFFFF_BFFF);
    repeat (6) cycle();

    // Back-to-back flushes, first one with a filled head and ID ready.
    n_idr = 1'b0;
    budget = 2;
    exp_req.push_back(32'h0000_4004);
    exp_req.push_back(32'h0000_4008);
    repeat (2) cycle();
    hold = 1'b1;
    n_flush = 1'b1;
    n_redir = 32'h0000_2000;
    n_idr = 1'b1;
    cycle();
    chk("b2b_id_valid", 32'(id_valid_o), 0);
    n_redir = 32'h0000_3000;
    hold = 1'b0;
    cycle();
    chk("b2b_drop_first", 32'(dut.drop_cnt_q), 1);
    chk("b2b_req_valid", 32'(imem_req_valid_o), 0);
    n_flush = 1'b0;
    budget = 1;
    exp_req.push_back(32'h0000_3000);
    push_id(32'h0000_3000, 32'hFFFF_CFFF);
    cycle();
    chk("b2b_drop_second", 32'(dut.drop_cnt_q), 0);
    chk("b2b_outstanding", 32'(dut.outstanding_q), 0);
    repeat (5) cycle();

    // PC wraps around the top of the address space.
    n_flush = 1'b1;
    n_redir = 32'hFFFF_FFFE;
    cycle();
    n_flush = 1'b0;
    budget = 2;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    push_id(32'hFFFF_FFFC, 32'h0000_0003);
    push_id(32'h0000_0000, 32'hFFFF_FFFF);
    repeat (8) cycle();

    // Reset while the queue is full.
    n_idr = 1'b0;
    budget = 2;
    exp_req.push_back(32'h0000_0004);
    exp_req.push_back(32'h0000_0008);
    repeat (4) cycle();
    chk("full_id_valid", 32'(id_valid_o), 1);
    chk("full_head_pc", id_pc_o, 32'h0000_0004);
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    cycle();
    chk("rst2_id_valid", 32'(id_valid_o), 0);
    chk("rst2_req_addr", imem_req_addr_o, 32'h8000_0000);
    chk("rst2_outstanding", 32'(dut.outstanding_q), 0);
    chk("rst2_drop_cnt", 32'(dut.drop_cnt_q), 0);
    repeat (3) cycle();

    chk("sb_id_left", exp_pc.size(), 0);
    chk("sb_req_left", exp_req.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
